// File: rtl/nn_upscale_ctrl.sv
// nn_upscale_ctrl: nearest-neighbour upscale sequencer.
// Reads a SRC_W x SRC_H frame from a sync-read memory, streams it SCALE x larger.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            frame start request (ignored while busy)
//   busy, done       frame in progress / one-cycle completion pulse
//   src_rd_en/addr   memory read strobe and address
//   src_rd_data      memory data, valid the cycle after src_rd_en
//   out_valid/ready  output handshake
//   out_data         output pixel
//   out_sof/eol/eof  start of frame / end of line / end of frame
module nn_upscale_ctrl #(
  parameter int SRC_W = 160,
  parameter int SRC_H = 120,
  parameter int SCALE = 3,
  parameter int PIX_W = 8,
  parameter int AW    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             src_rd_en,
  output logic [AW-1:0]    src_rd_addr,
  input  logic [PIX_W-1:0] src_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int PW = $clog2(SCALE);

  localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SCALE - 1);
  localparam logic [AW-1:0] LINE   = AW'(SRC_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [XW-1:0]     sx;
  logic [PW-1:0]     phx;
  logic [YW-1:0]     sy;
  logic [PW-1:0]     phy;
  logic [AW-1:0]     base;
  logic [PIX_W-1:0]  pf_pix;
  logic              cap_q;

  logic              hs;
  logic [XW-1:0]     n_sx;
  logic [PW-1:0]     n_phx;
  logic [YW-1:0]     n_sy;
  logic [PW-1:0]     n_phy;
  logic [AW-1:0]     n_base;
  logic              n_eol;
  logic              n_eof;

  logic              a_sel;
  logic [XW-1:0]     a_sx;
  logic [YW-1:0]     a_sy;
  logic [PW-1:0]     a_phy;
  logic [AW-1:0]     a_base;
  logic [AW-1:0]     pf_addr;
  logic              pf_last;
  logic [PIX_W-1:0]  nx_pix;

  assign hs = out_valid && out_ready;

  // Position of the pixel that follows the one on the output.
  always_comb begin
    n_sx   = sx;
    n_phx  = phx;
    n_sy   = sy;
    n_phy  = phy;
    n_base = base;
    if (phx == P_LAST) begin
      n_phx = '0;
      if (sx == X_LAST) begin
        n_sx = '0;
        if (phy == P_LAST) begin
          n_phy  = '0;
          n_sy   = sy + YW'(1);
          n_base = base + LINE;
        end else begin
          n_phy = phy + PW'(1);
        end
      end else begin
        n_sx = sx + XW'(1);
      end
    end else begin
      n_phx = phx + PW'(1);
    end
  end

  assign n_eol = (n_phx == P_LAST) && (n_sx == X_LAST);
  assign n_eof = n_eol && (n_sy == Y_LAST) && (n_phy == P_LAST);

  // Group whose first pixel is being loaded: counters are still zero in
  // FILL, in RUN it is the post-handshake position.
  assign a_sel  = (state == S_RUN);
  assign a_sx   = a_sel ? n_sx   : sx;
  assign a_sy   = a_sel ? n_sy   : sy;
  assign a_phy  = a_sel ? n_phy  : phy;
  assign a_base = a_sel ? n_base : base;

  always_comb begin
    if (a_sx != X_LAST) begin
      pf_addr = a_base + AW'(a_sx) + AW'(1);
    end else if (a_phy != P_LAST) begin
      pf_addr = a_base;
    end else begin
      pf_addr = a_base + LINE;
    end
  end

  assign pf_last = (a_sx == X_LAST) && (a_phy == P_LAST) &&
                   (a_sy == Y_LAST);

  // With SCALE=2 the group can end in the same cycle the prefetched
  // word arrives, before pf_pix holds it.
  assign nx_pix = cap_q ? src_rd_data : pf_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sx          <= '0;
      phx         <= '0;
      sy          <= '0;
      phy         <= '0;
      base        <= '0;
      pf_pix      <= '0;
      cap_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      src_rd_en   <= 1'b0;
      src_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_eof     <= 1'b0;
    end else begin
      src_rd_en <= 1'b0;
      done      <= 1'b0;
      cap_q     <= src_rd_en;
      if (cap_q) begin
        pf_pix <= src_rd_data;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_PRIME;
            busy        <= 1'b1;
            src_rd_en   <= 1'b1;
            src_rd_addr <= '0;
            sx          <= '0;
            phx         <= '0;
            sy          <= '0;
            phy         <= '0;
            base        <= '0;
          end
        end
        S_PRIME: begin
          state <= S_FILL;
        end
        S_FILL: begin
          state     <= S_RUN;
          out_data  <= src_rd_data;
          out_valid <= 1'b1;
          out_sof   <= 1'b1;
          out_eol   <= 1'b0;
          out_eof   <= 1'b0;
          if (!pf_last) begin
            src_rd_en   <= 1'b1;
            src_rd_addr <= pf_addr;
          end
        end
        S_RUN: begin
          if (hs) begin
            if (out_eof) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_sof   <= 1'b0;
              out_eol   <= 1'b0;
              out_eof   <= 1'b0;
              done      <= 1'b1;
            end else begin
              sx      <= n_sx;
              phx     <= n_phx;
              sy      <= n_sy;
              phy     <= n_phy;
              base    <= n_base;
              out_sof <= 1'b0;
              out_eol <= n_eol;
              out_eof <= n_eof;
              if (phx == P_LAST) begin
                out_data <= nx_pix;
              end
              if ((n_phx == '0) && !pf_last) begin
                src_rd_en   <= 1'b1;
                src_rd_addr <= pf_addr;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_upscale_ctrl.sv
// tb_nn_upscale_ctrl: directed bench for nn_upscale_ctrl.
// Config A: 4x2 x3, config B: 3x1 x2 (prefetch bypass path).
module tb_nn_upscale_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0;
  logic       busy_a, done_a, rd_en_a;
  logic [3:0] addr_a;
  logic [7:0] rdata_a = '0;
  logic       valid_a;
  logic       ready_a = 1'b1;
  logic [7:0] data_a;
  logic       sof_a, eol_a, eof_a;

  logic       start_b = 1'b0;
  logic       busy_b, done_b, rd_en_b;
  logic [3:0] addr_b;
  logic [7:0] rdata_b = '0;
  logic       valid_b;
  logic       ready_b = 1'b1;
  logic [7:0] data_b;
  logic       sof_b, eol_b, eof_b;

  int n_chk  = 0;
  int n_pass = 0;

  nn_upscale_ctrl #(
    .SRC_W(4), .SRC_H(2), .SCALE(3), .PIX_W(8), .AW(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .busy(busy_a), .done(done_a),
    .src_rd_en(rd_en_a), .src_rd_addr(addr_a),
    .src_rd_data(rdata_a),
    .out_valid(valid_a), .out_ready(ready_a),
    .out_data(data_a), .out_sof(sof_a),
    .out_eol(eol_a), .out_eof(eof_a)
  );

  nn_upscale_ctrl #(
    .SRC_W(3), .SRC_H(1), .SCALE(2), .PIX_W(8), .AW(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .busy(busy_b), .done(done_b),
    .src_rd_en(rd_en_b), .src_rd_addr(addr_b),
    .src_rd_data(rdata_b),
    .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_b), .out_sof(sof_b),
    .out_eol(eol_b), .out_eof(eof_b)
  );

  // Source memories hold mem[a] = a.
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= 8'(addr_a);
    if (rd_en_b) rdata_b <= 8'(addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_a(input bit rnd, input bit pre, input bit poke,
                       input bit chain, input int abort_at);
    int k, reads, first_v, done_t, dones, ln, col, gy;
    bit stall, eof_hs, fin;
    logic [7:0] pd;
    logic [2:0] pfl;
    k = 0; reads = 0; first_v = -1; done_t = -1; dones = 0;
    stall = 0; eof_hs = 0; fin = 0; pd = '0; pfl = '0;
    if (!pre) begin
      @(negedge clk);
      start_a = 1'b1;
    end
    for (int t = 0; t < 600 && !fin; t++) begin
      @(negedge clk);
      start_a = poke && (t == 10 || eof_hs);
      ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (abort_at >= 0 && k == abort_at && valid_a) begin
        rst_n = 1'b0;
        #1;
        chk("rst_flags",
            {valid_a, sof_a, eol_a, eof_a, busy_a, done_a, rd_en_a}, 0);
        chk("rst_data", data_a, 0);
        chk("rst_addr", addr_a, 0);
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("abort_no_done", done_a, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1;
      end else begin
        if (t == 0) begin
          chk("prime_rd", {rd_en_a, busy_a}, 2'b11);
          chk("prime_addr", addr_a, 0);
        end
        if (rd_en_a) begin
          gy = reads / 4;
          chk("rd_addr", addr_a, (gy / 3) * 4 + reads % 4);
          reads++;
        end
        if (valid_a && first_v < 0) begin
          first_v = t;
          chk("first_valid", t, 2);
        end
        if (stall) begin
          chk("hold_valid", valid_a, 1);
          chk("hold_pix", {sof_a, eol_a, eof_a, data_a}, {pfl, pd});
        end
        stall = valid_a && !ready_a;
        pd = data_a;
        pfl = {sof_a, eol_a, eof_a};
        eof_hs = 0;
        if (valid_a && ready_a) begin
          ln = k / 12;
          col = k % 12;
          chk("pix_data", data_a, (ln / 3) * 4 + col / 3);
          chk("pix_flags", {sof_a, eol_a, eof_a},
              {k == 0, col == 11, k == 71});
          if (!rnd) chk("no_gap", t, k + 2);
          eof_hs = eof_a;
          k++;
        end
        if (done_a) begin
          dones++;
          done_t = t;
          chk("done_busy", busy_a, 1);
          chk("done_valid", valid_a, 0);
          if (!rnd) chk("done_cycle", t, 74);
        end else if (done_t >= 0) begin
          chk("idle_busy", busy_a, 0);
          fin = 1;
        end
      end
    end
    if (abort_at < 0) begin
      if (!fin) chk("a_timeout", 0, 1);
      chk("pix_count", k, 72);
      chk("reads", reads, 24);
      chk("done_pulses", dones, 1);
      if (chain) start_a = 1'b1;
    end
  endtask

  task automatic run_b();
    int k, reads, col;
    bit fin;
    k = 0; reads = 0; fin = 0;
    @(negedge clk);
    start_b = 1'b1;
    for (int t = 0; t < 100 && !fin; t++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      if (rd_en_b) begin
        chk("b_rd_addr", addr_b, reads % 3);
        reads++;
      end
      if (valid_b && ready_b) begin
        col = k % 6;
        chk("b_pix", data_b, col / 2);
        chk("b_flags", {sof_b, eol_b, eof_b},
            {k == 0, col == 5, k == 11});
        chk("b_no_gap", t, k + 2);
        k++;
      end
      if (done_b) begin
        chk("b_done_cycle", t, 14);
        fin = 1;
      end
    end
    if (!fin) chk("b_timeout", 0, 1);
    chk("b_count", k, 12);
    chk("b_reads", reads, 6);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_a", {busy_a, done_a, rd_en_a, valid_a,
                    sof_a, eol_a, eof_a}, 0);
    chk("reset_a_data", {addr_a, data_a}, 0);
    chk("reset_b", {busy_b, done_b, rd_en_b, valid_b,
                    sof_b, eol_b, eof_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full rate, start poked in RUN and in DONE.
    run_a(1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Random backpressure, then a start in the first IDLE cycle.
    run_a(1'b1, 1'b0, 1'b1, 1'b1, -1);
    run_a(1'b0, 1'b1, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Abort at output pixel 30, then a clean frame.
    run_a(1'b0, 1'b0, 1'b0, 1'b0, 30);
    repeat (2) @(negedge clk);
    run_a(1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);

    run_b();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
